// File: rtl/mem_port_arbiter.sv
// Shares the core's single SRAM-like memory port between fetch and load/store traffic.
// Define ARB_RR_EN for round-robin tie-breaking; the default build gives data fixed priority.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              inst_req_i,
    input  logic [ADDR_W-1:0] inst_addr_i,
    output logic              inst_addr_ok_o,
    output logic              inst_data_ok_o,
    output logic [DATA_W-1:0] inst_rdata_o,

    input  logic              data_req_i,
    input  logic              data_wr_i,
    input  logic [1:0]        data_size_i,
    input  logic [ADDR_W-1:0] data_addr_i,
    input  logic [DATA_W-1:0] data_wdata_i,
    output logic              data_addr_ok_o,
    output logic              data_data_ok_o,
    output logic [DATA_W-1:0] data_rdata_o,

    output logic              bus_req_o,
    output logic              bus_wr_o,
    output logic [1:0]        bus_size_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic              bus_addr_ok_i,
    input  logic              bus_data_ok_i,
    input  logic [DATA_W-1:0] bus_rdata_i,

    output logic              stall_from_if_o,
    output logic              stall_from_mem_o,
    output logic              proto_err_o
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAddr = 2'd1,
        StData = 2'd2
    } state_e;

    typedef enum logic {
        OwnInst = 1'b0,
        OwnData = 1'b1
    } owner_e;

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic              bus_wr_q, bus_wr_d;
    logic [1:0]        bus_size_q, bus_size_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic              proto_err_q, proto_err_d;

    logic grant_window;
    logic grant_now;
    logic data_on_tie;
    logic pick_data;
    logic addr_hs;
    logic data_hs;
    logic busy;

    // Arbitration happens in IDLE, or alongside the response so the next request has no bubble.
    assign grant_window = (state_q == StIdle) || ((state_q == StData) && bus_data_ok_i);
    assign grant_now    = grant_window && (inst_req_i || data_req_i);

`ifdef ARB_RR_EN
    owner_e last_grant_q, last_grant_d;

    assign data_on_tie = (last_grant_q == OwnInst);

    always_comb begin
        last_grant_d = last_grant_q;
        if (grant_now) begin
            last_grant_d = pick_data ? OwnData : OwnInst;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_grant_q <= OwnInst;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    assign data_on_tie = 1'b1;
`endif

    assign pick_data = data_req_i && (!inst_req_i || data_on_tie);

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        bus_wr_d    = bus_wr_q;
        bus_size_d  = bus_size_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;

        unique case (state_q)
            StIdle: state_d = StIdle;
            StAddr: begin
                if (bus_addr_ok_i) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (bus_data_ok_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (grant_now) begin
            state_d = StAddr;
            if (pick_data) begin
                owner_d     = OwnData;
                bus_wr_d    = data_wr_i;
                bus_size_d  = data_size_i;
                bus_addr_d  = data_addr_i;
                bus_wdata_d = data_wdata_i;
            end else begin
                // Fetches are always word reads.
                owner_d     = OwnInst;
                bus_wr_d    = 1'b0;
                bus_size_d  = 2'd2;
                bus_addr_d  = inst_addr_i;
                bus_wdata_d = '0;
            end
        end
    end

    // A response with no transaction in flight means the bus side is out of step.
    assign proto_err_d = proto_err_q || (bus_data_ok_i && (state_q != StData));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            owner_q     <= OwnInst;
            bus_wr_q    <= 1'b0;
            bus_size_q  <= 2'd0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            bus_wr_q    <= bus_wr_d;
            bus_size_q  <= bus_size_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign addr_hs = (state_q == StAddr) && bus_addr_ok_i;
    assign data_hs = (state_q == StData) && bus_data_ok_i;
    assign busy    = (state_q != StIdle);

    assign bus_req_o   = (state_q == StAddr);
    assign bus_wr_o    = bus_wr_q;
    assign bus_size_o  = bus_size_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_wdata_o = bus_wdata_q;

    assign inst_addr_ok_o = addr_hs && (owner_q == OwnInst);
    assign data_addr_ok_o = addr_hs && (owner_q == OwnData);
    assign inst_data_ok_o = data_hs && (owner_q == OwnInst);
    assign data_data_ok_o = data_hs && (owner_q == OwnData);

    assign inst_rdata_o = bus_rdata_i;
    assign data_rdata_o = bus_rdata_i;

    assign stall_from_if_o  = (inst_req_i || ((owner_q == OwnInst) && busy)) && !inst_data_ok_o;
    assign stall_from_mem_o = (data_req_i || ((owner_q == OwnData) && busy)) && !data_data_ok_o;

    assign proto_err_o = proto_err_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter sharing the CPU's single SRAM-like memory port between instruction fetch (`inst_*`) and load/store (`data_*`). It sits between the core and the bus-protocol bridge. It registers the winning request, keeps at most one transaction outstanding, routes the response back to its owner, and produces the `stall_from_if` / `stall_from_mem` signals consumed by the hazard unit.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-high reset
- `inst_req`  in  1  fetch request; held with `inst_addr` until `inst_addr_ok`
- `inst_addr`  in  ADDR_W  fetch address
- `inst_addr_ok`  out  1  fetch request accepted by bus (1-cycle pulse)
- `inst_data_ok`  out  1  fetch data valid (1-cycle pulse)
- `inst_rdata`  out  DATA_W  fetch read data
- `data_req`  in  1  load/store request; held with its fields until `data_addr_ok`
- `data_wr`  in  1  1 = store
- `data_size`  in  2  0 = byte, 1 = half, 2 = word
- `data_addr`  in  ADDR_W  load/store address
- `data_wdata`  in  DATA_W  store data
- `data_addr_ok`  out  1  load/store accepted (pulse)
- `data_data_ok`  out  1  load data valid / store complete (pulse)
- `data_rdata`  out  DATA_W  load data
- `bus_req`, `bus_wr`, `bus_size`, `bus_addr`, `bus_wdata`  out  1/1/2/ADDR_W/DATA_W  shared port request
- `bus_addr_ok`  in  1  bus accepted request
- `bus_data_ok`  in  1  bus response valid
- `bus_rdata`  in  DATA_W  bus read data
- `stall_from_if`  out  1  fetch pending, no data this cycle
- `stall_from_mem`  out  1  load/store pending, no data this cycle
- `proto_err`  out  1  sticky: `bus_data_ok` seen outside DATA state

## Operation
- States:
  - IDLE: no transaction.
  - ADDR: `bus_req`=1, waiting for `bus_addr_ok`.
  - DATA: waiting for `bus_data_ok`.
- Grant is evaluated only in IDLE, or in DATA in the cycle `bus_data_ok`=1 (zero-bubble back-to-back).
  - If any `req` is high at that point, the winner's fields are latched into `bus_*` registers, `owner` is recorded, and the next state is ADDR.
  - Otherwise the next state is IDLE.
- Default priority: `data` beats `inst` (fixed).
- ADDR with `bus_addr_ok`=1: `<owner>_addr_ok`=1 combinationally in that cycle; next state DATA. Otherwise the state stays in ADDR and the latched fields stay stable.
- DATA with `bus_data_ok`=1:
  - `<owner>_data_ok`=1 combinationally.
  - `inst_rdata` and `data_rdata` both equal `bus_rdata` (pass-through).
- Requester `req` deasserting after grant does not cancel the transaction; its response is still delivered.
- In the DATA+`bus_data_ok` cycle, the owner's `req` is treated as a new request.
- `bus_data_ok` in IDLE or ADDR: ignored, and `proto_err` is set until reset.
- Write data/size/wr are forwarded unchanged. The block does no alignment checking; address errors are raised upstream.
- `stall_from_if` = (`inst_req` | (`owner`==inst & state≠IDLE)) & ~`inst_data_ok`.
- `stall_from_mem` = (`data_req` | (`owner`==data & state≠IDLE)) & ~`data_data_ok`.

## Timing
- Reset (async assert, takes effect immediately):
  - state IDLE, `owner`=inst, `last_grant`=inst.
  - All `bus_*` registers 0, `proto_err`=0.
  - All `*_ok` outputs 0; `rdata` outputs follow `bus_rdata`.
- Minimum latency, request seen at cycle 0 in IDLE:
  - Cycle 1: `bus_req`=1. With `bus_addr_ok`=1 in cycle 1, `addr_ok` is also in cycle 1.
  - Earliest `data_ok` is cycle 2.
- Back-to-back: `bus_req` for the next grant is high in the cycle after the previous `bus_data_ok`.
- Both `req` high simultaneously: exactly one grant; the loser keeps stalling until its own grant.
- Reset mid-transaction: in-flight transaction is dropped with no `data_ok`. The bus side is expected to be reset together with the arbiter.

## Configuration
- `ARB_RR_EN`:
  - Defined: round-robin. On a simultaneous request, the requester not equal to `last_grant` wins. `last_grant` updates on each grant. Reset value inst, so data wins the first tie.
  - Undefined: fixed data-over-inst priority. `last_grant` is not implemented.

## Test plan
- Single fetch, `inst_addr`=0xBFC0_0000, bus `addr_ok` immediate, `data_ok` 3 cycles later with 0x3C08_0001:
  - `bus_req` high in cycle 1 only; `inst_addr_ok` in cycle 1; `inst_data_ok`=1 with `inst_rdata`=0x3C08_0001 in cycle 4.
  - `stall_from_if`=1 in cycles 0–3.
- Simultaneous `inst_req` and store (`data_addr`=0x8000_0010, `data_wdata`=0xDEAD_BEEF, size 2):
  - Data is granted first; `bus_wr`=1, `bus_wdata`=0xDEAD_BEEF.
  - Fetch is granted in the `data_data_ok` cycle, and its `bus_req` is high the next cycle.
- `bus_addr_ok` withheld 5 cycles while the owner drops `req` after 1 cycle:
  - `bus_addr`/`bus_req` stay stable for all 5 cycles.
  - The response is still returned to that owner.
- Continuous requests on both sides for 8 transactions:
  - Without `ARB_RR_EN`, all data requests are served before any fetch.
  - With `ARB_RR_EN`, grants alternate data, inst, data, …
- `bus_data_ok` pulsed in IDLE: no `*_data_ok` output; `proto_err`=1 until `rst`.
- `rst` asserted in DATA state: all outputs at reset values in the same cycle; a `bus_data_ok` arriving after reset release sets `proto_err`.
